// File: rtl/bspi_sbr.sv
// rtl/bspi_sbr.sv - oversampled SPI slave that turns boot frames into SRAM-style bus accesses
module bspi_sbr #(
    parameter int AW    = 11,
    parameter int DW    = 32,
    parameter int DUMMY = 1,
    parameter int SYNC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_bcf,
    input  logic              io_scs,
    input  logic              io_sck,
    input  logic              io_sdi,
    output logic              io_sdo,
    output logic              bcsb,
    output logic [DW/8-1:0]   bweb,
    output logic [AW-1:0]     badr,
    output logic [DW-1:0]     bdti,
    input  logic [DW-1:0]     bdto,
    output logic              act
);
    localparam int NB = DW / 8;
    localparam int AB = (AW + 7) / 8;
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADR, S_DMY, S_RDAT, S_WDAT, S_SKIP
    } state_t;

    state_t            state_q;
    logic [SYNC-1:0]   scs_sq, sck_sq, sdi_sq;
    logic              scs_pq, sck_pq;
    logic [2:0]        bc_q;
    logic [6:0]        rx_q;
    logic              is_rd_q;
    logic [1:0]        cnt_q;
    logic [AW-1:0]     addr_q;
    logic [LW-1:0]     lane_q;
    logic [NB-1:0]     mask_q;
    logic [DW-1:0]     wbuf_q, rbuf_q;
    logic [7:0]        sh_q;
    logic              sdo_q;
    logic [1:0]        rd_q;
    logic              bcsb_q;
    logic [NB-1:0]     bweb_q;
    logic [AW-1:0]     badr_q;
    logic [DW-1:0]     bdti_q;

    logic              scs_s, sck_s, sdi_s;
    logic              sck_rise, sck_fall, scs_rise, scs_fall;
    logic [7:0]        byte_w;
    logic              byte_done, lane_last;
    logic [AW-1:0]     adr_d, addr_inc;
    logic [DW-1:0]     wbuf_d;
    logic [NB-1:0]     mask_d;

    assign scs_s     = scs_sq[SYNC-1];
    assign sck_s     = sck_sq[SYNC-1];
    assign sdi_s     = sdi_sq[SYNC-1];
    assign sck_rise  = sck_s & ~sck_pq;
    assign sck_fall  = ~sck_s & sck_pq;
    assign scs_rise  = scs_s & ~scs_pq;
    assign scs_fall  = ~scs_s & scs_pq;
    assign byte_w    = {rx_q, sdi_s};
    assign byte_done = sck_rise && (bc_q == 3'd7);
    assign lane_last = (lane_q == LW'(NB - 1));
    assign addr_inc  = addr_q + AW'(1);

    // Address bytes shift in MSB first; only the low AW bits survive.
    if (AW > 8) begin : g_adr_wide
        assign adr_d = {addr_q[AW-9:0], byte_w};
    end else begin : g_adr_narrow
        assign adr_d = byte_w[AW-1:0];
    end

    always_comb begin
        wbuf_d = wbuf_q;
        mask_d = mask_q;
        wbuf_d[lane_q*8 +: 8] = byte_w;
        mask_d[lane_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            scs_sq  <= '1;
            sck_sq  <= '0;
            sdi_sq  <= '0;
            scs_pq  <= 1'b1;
            sck_pq  <= 1'b0;
            bc_q    <= '0;
            rx_q    <= '0;
            is_rd_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            mask_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            sh_q    <= '0;
            sdo_q   <= 1'b0;
            rd_q    <= '0;
            bcsb_q  <= 1'b1;
            bweb_q  <= '1;
            badr_q  <= '0;
            bdti_q  <= '0;
        end else begin
            scs_sq <= {scs_sq[SYNC-2:0], io_scs};
            sck_sq <= {sck_sq[SYNC-2:0], io_sck};
            sdi_sq <= {sdi_sq[SYNC-2:0], io_sdi};
            scs_pq <= scs_s;
            sck_pq <= sck_s;
            bcsb_q <= 1'b1;
            bweb_q <= '1;
            rd_q   <= {rd_q[0], 1'b0};
            if (rd_q[1]) rbuf_q <= bdto;

            if (state_q != S_IDLE && (!io_bcf || scs_rise)) begin
                // Flush any bytes still held in the write buffer.
                if (state_q == S_WDAT && mask_q != '0) begin
                    bcsb_q <= 1'b0;
                    bweb_q <= ~mask_q;
                    bdti_q <= wbuf_q;
                    badr_q <= addr_q;
                end
                state_q <= S_IDLE;
                mask_q  <= '0;
                lane_q  <= '0;
                sdo_q   <= 1'b0;
            end else if (state_q == S_IDLE) begin
                if (io_bcf && scs_fall) begin
                    state_q <= S_CMD;
                    bc_q    <= '0;
                    cnt_q   <= '0;
                    lane_q  <= '0;
                    mask_q  <= '0;
                    sdo_q   <= 1'b0;
                end
            end else begin
                if (sck_rise) begin
                    rx_q <= byte_w[6:0];
                    bc_q <= bc_q + 3'd1;
                end
                if (byte_done) begin
                    case (state_q)
                        S_CMD: begin
                            if (byte_w == 8'h02 || byte_w == 8'h03) begin
                                is_rd_q <= byte_w[0];
                                cnt_q   <= '0;
                                state_q <= S_ADR;
                            end else begin
                                state_q <= S_SKIP;
                            end
                        end
                        S_ADR: begin
                            addr_q <= adr_d;
                            cnt_q  <= cnt_q + 2'd1;
                            if (cnt_q == 2'(AB - 1)) begin
                                cnt_q <= '0;
                                if (is_rd_q) begin
                                    state_q <= S_DMY;
                                    bcsb_q  <= 1'b0;
                                    badr_q  <= adr_d;
                                    rd_q    <= {rd_q[0], 1'b1};
                                end else begin
                                    state_q <= S_WDAT;
                                end
                            end
                        end
                        S_DMY: cnt_q <= cnt_q + 2'd1;
                        S_WDAT: begin
                            wbuf_q <= wbuf_d;
                            if (lane_last) begin
                                bcsb_q <= 1'b0;
                                bweb_q <= ~mask_d;
                                bdti_q <= wbuf_d;
                                badr_q <= addr_q;
                                addr_q <= addr_inc;
                                mask_q <= '0;
                                lane_q <= '0;
                            end else begin
                                mask_q <= mask_d;
                                lane_q <= lane_q + LW'(1);
                            end
                        end
                        default: ;
                    endcase

                    // Load the next read lane; after the last one, prefetch the next word.
                    if ((state_q == S_DMY && cnt_q == 2'(DUMMY - 1)) || state_q == S_RDAT) begin
                        state_q <= S_RDAT;
                        sh_q    <= rbuf_q[lane_q*8 +: 8];
                        if (lane_last) begin
                            lane_q <= '0;
                            addr_q <= addr_inc;
                            bcsb_q <= 1'b0;
                            badr_q <= addr_inc;
                            rd_q   <= {rd_q[0], 1'b1};
                        end else begin
                            lane_q <= lane_q + LW'(1);
                        end
                    end
                end
                if (sck_fall) begin
                    if (state_q == S_RDAT) begin
                        sdo_q <= sh_q[7];
                        sh_q  <= {sh_q[6:0], 1'b0};
                    end else begin
                        sdo_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign io_sdo = sdo_q & ~scs_s;
    assign bcsb   = bcsb_q;
    assign bweb   = bweb_q;
    assign badr   = badr_q;
    assign bdti   = bdti_q;
    assign act    = (state_q != S_IDLE);
endmodule
